// File: rtl/xor_stim_driver.sv
// Clocked LFSR stimulus driver and flag scoreboard for the XOR/concatenation comparator.
// Optional XOR_STIM_CAPTURE_EN adds first_fail_x, the vector that produced the first flag in a run.
module xor_stim_driver #(
  parameter int unsigned N_VEC = 1024,
  parameter logic [63:0] SEED  = 64'h0123_4567_89AB_CDEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [63:0]      x,
  input  logic             badness,
  input  logic             goodness,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] good_cnt
`ifdef XOR_STIM_CAPTURE_EN
  ,
  output logic [63:0]      first_fail_x
`endif
);

  localparam logic [63:0]      SeedEff = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LastVec = CNT_W'(N_VEC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [63:0]      x_q, x_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic             fail_q, fail_d;
  logic [63:0]      lfsr_next;

  assign lfsr_next = {x_q[62:0], x_q[63] ^ x_q[62] ^ x_q[60] ^ x_q[59]};

`ifdef XOR_STIM_CAPTURE_EN
  logic [63:0] ffx_q, ffx_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    vec_d   = vec_q;
    bad_d   = bad_q;
    good_d  = good_q;
    fail_d  = fail_q;
`ifdef XOR_STIM_CAPTURE_EN
    ffx_d   = ffx_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          x_d     = SeedEff;
          vec_d   = '0;
          bad_d   = '0;
          good_d  = '0;
          fail_d  = 1'b0;
`ifdef XOR_STIM_CAPTURE_EN
          ffx_d   = '0;
`endif
        end
      end
      StRun: begin
        // abort freezes x and counters; start is ignored while running
        if (abort) begin
          state_d = StDone;
        end else begin
          x_d   = lfsr_next;
          vec_d = vec_q + CntOne;
          if (badness)  bad_d  = bad_q + CntOne;
          if (goodness) good_d = good_q + CntOne;
          fail_d = (bad_d != '0) || (good_d != '0);
`ifdef XOR_STIM_CAPTURE_EN
          // fail_q is still clear only if no earlier sample in this run flagged
          if (!fail_q && (badness || goodness)) ffx_d = x_q;
`endif
          if (vec_q == LastVec) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= SeedEff;
      vec_q   <= '0;
      bad_q   <= '0;
      good_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      vec_q   <= vec_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      fail_q  <= fail_d;
    end
  end

`ifdef XOR_STIM_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ffx_q <= '0;
    else     ffx_q <= ffx_d;
  end

  assign first_fail_x = ffx_q;
`endif

  assign x        = x_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign fail     = fail_q;
  assign vec_cnt  = vec_q;
  assign bad_cnt  = bad_q;
  assign good_cnt = good_q;

endmodule

// File: tb/tb_xor_stim_driver.sv
// Directed bench for xor_stim_driver: a table of runs with hand-computed counts plus
// hand-written sequences for LFSR stepping, ignored start, and reset during a run.
module tb_xor_stim_driver;

  localparam logic [63:0] SEED   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEED_2 = 64'h0246_8ACF_1357_9BDE;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [63:0] x;
  logic        badness, goodness, busy, done, fail;
  logic [15:0] vec_cnt, bad_cnt, good_cnt;
  logic [1:0]  bad_mode, good_mode;
`ifdef XOR_STIM_CAPTURE_EN
  logic [63:0] first_fail_x;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // mode 0: tied low, 1: tied high, 2: follow one bit of x
  assign badness  = (bad_mode == 2'd1)  || (bad_mode == 2'd2 && x[31]);
  assign goodness = (good_mode == 2'd1) || (good_mode == 2'd2 && x[63]);

  xor_stim_driver #(
    .N_VEC (16),
    .SEED  (SEED),
    .CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .x            (x),
    .badness      (badness),
    .goodness     (goodness),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .vec_cnt      (vec_cnt),
    .bad_cnt      (bad_cnt),
    .good_cnt     (good_cnt)
`ifdef XOR_STIM_CAPTURE_EN
    ,
    .first_fail_x (first_fail_x)
`endif
  );

  typedef struct {
    int          bad_mode;
    int          good_mode;
    int          abort_at;   // RUN edge carrying abort, 0 = none
    int          exp_cyc;
    int          exp_vec;
    int          exp_bad;
    int          exp_good;
    logic        exp_fail;
    logic [63:0] exp_ffx;
  } run_t;

  run_t tbl[7];

  function automatic logic [63:0] lfsr(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_one(input int i);
    int          cyc;
    logic [63:0] exp_x;
    bit          x_ok;
    bit          aborted;
    bad_mode  = 2'(tbl[i].bad_mode);
    good_mode = 2'(tbl[i].good_mode);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("run%0d_busy", i), {63'b0, busy}, 64'd1);
    chk($sformatf("run%0d_vec_clr", i), {48'b0, vec_cnt}, 64'd0);
    exp_x = SEED;
    x_ok  = 1'b1;
    cyc   = 0;
    while (!done && cyc < 200) begin
      if (x !== exp_x) x_ok = 1'b0;
      aborted = (tbl[i].abort_at == cyc + 1);
      if (aborted) abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      cyc++;
      if (!aborted) exp_x = lfsr(exp_x);
    end
    chk($sformatf("run%0d_cycles", i), 64'(cyc), 64'(tbl[i].exp_cyc));
    chk($sformatf("run%0d_x_seq", i), {63'b0, x_ok}, 64'd1);
    chk($sformatf("run%0d_done", i), {62'b0, busy, done}, 64'd1);
    chk($sformatf("run%0d_vec", i), {48'b0, vec_cnt}, 64'(tbl[i].exp_vec));
    chk($sformatf("run%0d_bad", i), {48'b0, bad_cnt}, 64'(tbl[i].exp_bad));
    chk($sformatf("run%0d_good", i), {48'b0, good_cnt}, 64'(tbl[i].exp_good));
    chk($sformatf("run%0d_fail", i), {63'b0, fail}, {63'b0, tbl[i].exp_fail});
    if (tbl[i].abort_at != 0) chk($sformatf("run%0d_x_frozen", i), x, exp_x);
`ifdef XOR_STIM_CAPTURE_EN
    chk($sformatf("run%0d_ffx", i), first_fail_x, tbl[i].exp_ffx);
`endif
  endtask

  initial begin
    int          cyc;
    logic [63:0] v8;

    // x[63] of vectors 1..8 walks seed bits 63..56 (0x01), so vector 8 is the first hit
    v8 = SEED;
    for (int k = 0; k < 7; k++) v8 = lfsr(v8);

    // x[31] over 16 vectors = seed bits 31..16 (0x89AB, 8 ones); x[63] = bits 63..48 (0x0123, 4 ones)
    tbl[0] = '{0, 0, 0, 16, 16,  0, 0, 1'b0, 64'h0};
    tbl[1] = '{2, 0, 0, 16, 16,  8, 0, 1'b1, SEED};
    tbl[2] = '{0, 2, 0, 16, 16,  0, 4, 1'b1, v8};
    tbl[3] = '{2, 2, 0, 16, 16,  8, 4, 1'b1, SEED};
    tbl[4] = '{0, 0, 5,  5,  4,  0, 0, 1'b0, 64'h0};
    tbl[5] = '{2, 0, 3,  3,  2,  1, 0, 1'b1, SEED};
    tbl[6] = '{1, 0, 0, 16, 16, 16, 0, 1'b1, SEED};

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    bad_mode  = 2'd0;
    good_mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_x", x, SEED);
    chk("rst_flags", {61'b0, busy, done, fail}, 64'd0);
    chk("rst_cnts", {16'b0, vec_cnt, bad_cnt, good_cnt}, 64'd0);
`ifdef XOR_STIM_CAPTURE_EN
    chk("rst_ffx", first_fail_x, 64'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", {62'b0, busy, done}, 64'd0);

    // LFSR first two vectors, then a start pulse mid-run that must be ignored
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("lfsr_v1", x, SEED);
    @(posedge clk);
    #1;
    chk("lfsr_v2", x, SEED_2);
    chk("lfsr_v2_cnt", {48'b0, vec_cnt}, 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("ign_start_cycles", 64'(cyc), 64'd16);
    chk("ign_start_vec", {48'b0, vec_cnt}, 64'd16);

    for (int i = 0; i < 7; i++) run_one(i);

    // asynchronous reset in the middle of a run with nonzero counts
    bad_mode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_flags", {61'b0, busy, done, fail}, 64'd0);
    chk("midrst_x", x, SEED);
    chk("midrst_cnts", {16'b0, vec_cnt, bad_cnt, good_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xor_stim_driver.md
# xor_stim_driver

Self-checking stimulus driver for the combinational XOR/concatenation comparator (`top`). It generates a 64-bit pseudo-random vector stream on `x` and samples the comparator's `badness`/`goodness` flags for every vector. It reports per-run mismatch counts and a pass/fail verdict. It sits directly in front of the comparator in the simulation harness and replaces ad-hoc `initial`-block stimulus with a clocked, restartable run controller.

## Interface
- `N_VEC`, default 1024: vectors per run; legal range 1 … 2^CNT_W−1.
- `SEED`, default 64'h0123_4567_89AB_CDEF: LFSR start value; 0 is replaced by 64'h1.
- `CNT_W`, default 16: width of all counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- `abort`  in  1  single-cycle pulse; ends a run early.
- `x`  out  64  vector driven to the comparator; registered.
- `badness`  in  1  comparator flag; must be 0 for every vector.
- `goodness`  in  1  comparator flag; must be 0 for every vector.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE; holds until the next `start`.
- `fail`  out  1  registered; equals `bad_cnt != 0 || good_cnt != 0`.
- `vec_cnt`  out  CNT_W  vectors sampled in the current or last run.
- `bad_cnt`  out  CNT_W  vectors with `badness` = 1.
- `good_cnt`  out  CNT_W  vectors with `goodness` = 1.
- `first_fail_x`  out  64  present only with `XOR_STIM_CAPTURE_EN`.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE after the N_VEC-th sample, or on `abort`.
  - DONE→RUN on `start`.
- `start` is ignored while in RUN.
- `abort` is ignored in IDLE and DONE.
- If `start` and `abort` are asserted together in RUN, `abort` wins.
- On entry to RUN, all of the following happen on the same edge:
  - `x` is loaded with SEED, or 64'h1 if SEED is 0.
  - `vec_cnt`, `bad_cnt` and `good_cnt` are cleared.
  - `fail` is cleared.
  - The capture register is cleared.
- LFSR is Fibonacci, polynomial x^64+x^63+x^61+x^60+1.
  - Next value: `x_next = {x[62:0], x[63]^x[62]^x[60]^x[59]}`.
  - The LFSR advances only in RUN.
- The comparator is combinational, so `badness`/`goodness` sampled on a RUN edge belong to the `x` held during that cycle.
- On each non-abort RUN edge:
  - `vec_cnt` increments by 1.
  - `bad_cnt` increments if `badness` = 1.
  - `good_cnt` increments if `goodness` = 1.
- Because N_VEC ≤ 2^CNT_W−1, no counter can wrap.
- On the abort edge:
  - Flags are not sampled and counters are not updated.
  - `x` holds its value.
- In DONE and IDLE, `x` and all counters hold their values.

## Timing
- Reset (asynchronous) puts the block in IDLE with:
  - `x` = SEED (or 1 if SEED is 0).
  - `busy` = 0, `done` = 0, `fail` = 0.
  - All counters = 0.
  - `first_fail_x` = 0.
- Reset asserted mid-run aborts the run immediately. Nothing is retained.
- `start` at edge T:
  - `busy` = 1 and `x` = SEED from T+1.
  - The first sample is taken at edge T+1.
- An uninterrupted run samples at edges T+1 … T+N_VEC.
  - From edge T+N_VEC: `busy` = 0 and `done` = 1.
  - `fail` is valid in the same cycle as `done`.
- `abort` at edge A: `busy` = 0 and `done` = 1 from A+1. `vec_cnt` equals the number of edges sampled before A.
- Back-to-back runs: `start` in the first DONE cycle re-enters RUN on the next edge, with no dead cycle beyond DONE.

## Configuration
- Macro: `XOR_STIM_CAPTURE_EN`.
- When defined:
  - Port `first_fail_x` exists.
  - On the first RUN sample in a run where `badness | goodness` = 1, it captures the `x` of that cycle.
  - It then holds that value until the next run start or reset. Later failures do not overwrite it.
- When undefined:
  - The port and the capture register are absent.
  - All other behaviour is identical.

## Test plan
- `badness`/`goodness` tied 0, N_VEC = 16, `start` pulse → `done` exactly 16 cycles after `start`; `vec_cnt` = 16, `bad_cnt` = `good_cnt` = 0, `fail` = 0.
- LFSR check, SEED default → first `x` = 64'h0123_4567_89AB_CDEF; second `x` = 64'h0246_8ACF_1357_9BDE (feedback bit = 0).
- `badness` driven from `x[31]`, N_VEC = 1 → `bad_cnt` = 1, `fail` = 1, `first_fail_x` = 64'h0123_4567_89AB_CDEF (capture enabled).
- `abort` on the 5th RUN edge, N_VEC = 100 → `done` on the next cycle; `vec_cnt` = 4; `x` frozen at the 5th vector.
- Reset asserted during RUN, then `start` → `x` = SEED, counters 0, and a full N_VEC run completes.
- `start` pulsed during RUN → ignored. Second `start` in DONE → counters cleared and a new run of N_VEC begins.
